ahb_sram_resp: RTL and testbench

- AHB-Lite slave (responder) that terminates transfers issued by the Cortex-M0 integration master port. It backs a byte-addressable on-chip SRAM.
- Supports byte, halfword and word transfers and a parameterised number of wait states.
- Returns the two-cycle ERROR response for illegal transfers.
- Sits behind the system address decoder and bus multiplexer, one instance per SRAM region.

---
 rtl/ahb_pkg.sv | 46 ++++
 rtl/ahb_sram_mem.sv | 34 +++
 rtl/ahb_sram_resp.sv | 141 ++++++++++++++
 tb/tb_ahb_sram_resp.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and byte-lane helpers for the SRAM responder.
// Also holds the responder's FSM state type and its debug view.
package ahb_pkg;

   localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
   localparam logic [1:0] HTRANS_SEQ    = 2'd3;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_ERR1 = 2'd2,
      ST_ERR2 = 2'd3
   } resp_state_e;

   typedef struct packed {
      resp_state_e state;
      logic [3:0]  cnt;
   } resp_dbg_t;

   // Little-endian byte strobe for a transfer of the given size at addr[1:0].
   function automatic logic [3:0] lane_strb(input logic [2:0] size, input logic [1:0] addr_lo);
      logic [3:0] strb;
      strb = 4'b0000;
      case (size)
         HSIZE_BYTE: strb = 4'b0001 << addr_lo;
         HSIZE_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
         HSIZE_WORD: strb = 4'b1111;
         default:    strb = 4'b0000;
      endcase
      return strb;
   endfunction

   function automatic logic size_legal(input logic [2:0] size, input logic [1:0] addr_lo);
      return (size == HSIZE_BYTE) ||
             (size == HSIZE_HALF && !addr_lo[0]) ||
             (size == HSIZE_WORD && addr_lo == 2'b00);
   endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// Word-organised SRAM array with per-byte write enable and a registered read port.
// Read-before-write: a read and a write on the same edge return the old word.
module ahb_sram_mem #(
   parameter int ADDR_WIDTH = 14
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [3:0]            wstrb,
   input  logic [ADDR_WIDTH-3:0] waddr,
   input  logic [31:0]           wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-3:0] raddr,
   output logic [31:0]           rdata
);

   localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/ahb_sram_resp.sv
// AHB-Lite SRAM responder: wait-state insertion, two-cycle ERROR for illegal
// transfers, and a write-to-read bypass so pipelined read-after-write sees new data.
module ahb_sram_resp
   import ahb_pkg::*;
#(
   parameter int ADDR_WIDTH  = 14,
   parameter int WAIT_STATES = 0
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic [2:0]  HSIZE,
   input  logic        HWRITE,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [31:0] HRDATA
);

   // Handshake: an address phase is taken on a rising edge where HSEL, HREADY and
   // an active HTRANS coincide and this slave is able to start a new data phase;
   // a data phase completes on the edge ending a cycle with HREADYOUT high.

   resp_state_e           state_q, state_d;
   logic [3:0]            cnt_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [2:0]            size_q;
   logic                  wr_q;
   logic [3:0]            byp_strb_q;
   logic [31:0]           byp_data_q;
   logic [31:0]           mem_rdata;

   logic       last_cycle, can_accept, accept, legal, accept_ok, commit, rd_start, same_word;
   logic [3:0] commit_strb;

   assign last_cycle  = (state_q == ST_DATA) && (cnt_q == 4'd0);
   assign can_accept  = (state_q == ST_IDLE) || (state_q == ST_ERR2) || last_cycle;
   assign accept      = can_accept && HSEL && HREADY &&
                        ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
   assign legal       = size_legal(HSIZE, HADDR[1:0]);
   assign accept_ok   = accept && legal;
   assign commit      = last_cycle && wr_q;
   assign commit_strb = lane_strb(size_q, addr_q[1:0]);
   assign rd_start    = accept_ok && !HWRITE;
   assign same_word   = (addr_q[ADDR_WIDTH-1:2] == HADDR[ADDR_WIDTH-1:2]);

   resp_dbg_t debug_unused;
   logic      addr_hi_unused;
   assign debug_unused   = '{state: state_q, cnt: cnt_q};
   assign addr_hi_unused = ^HADDR[31:ADDR_WIDTH];

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_ERR2: begin
            if (accept) state_d = legal ? ST_DATA : ST_ERR1;
            else        state_d = ST_IDLE;
         end
         ST_DATA: begin
            if (cnt_q != 4'd0) state_d = ST_DATA;
            else if (accept)   state_d = legal ? ST_DATA : ST_ERR1;
            else               state_d = ST_IDLE;
         end
         ST_ERR1: state_d = ST_ERR2;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      HREADYOUT = 1'b1;
      HRESP     = HRESP_OKAY;
      case (state_q)
         ST_DATA: HREADYOUT = (cnt_q == 4'd0);
         ST_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = HRESP_ERROR;
         end
         ST_ERR2: HRESP = HRESP_ERROR;
         default: ;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         cnt_q      <= 4'd0;
         addr_q     <= '0;
         size_q     <= 3'd0;
         wr_q       <= 1'b0;
         byp_strb_q <= 4'b0000;
         byp_data_q <= '0;
      end else begin
         if (accept_ok)                               cnt_q <= 4'(WAIT_STATES);
         else if (state_q == ST_DATA && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;

         if (accept) begin
            addr_q <= HADDR[ADDR_WIDTH-1:0];
            size_q <= HSIZE;
            wr_q   <= HWRITE && legal;
         end else if (last_cycle) begin
            wr_q   <= 1'b0;
         end

         // The array read below sees the pre-write word, so remember the lanes
         // being committed on this same edge and overlay them on the read data.
         if (rd_start) begin
            byp_strb_q <= (commit && same_word) ? commit_strb : 4'b0000;
            byp_data_q <= HWDATA;
         end
      end
   end

   ahb_sram_mem #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_mem (
      .clk  (HCLK),
      .rst_n(HRESETn),
      .we   (commit),
      .wstrb(commit_strb),
      .waddr(addr_q[ADDR_WIDTH-1:2]),
      .wdata(HWDATA),
      .re   (rd_start),
      .raddr(HADDR[ADDR_WIDTH-1:2]),
      .rdata(mem_rdata)
   );

   always_comb begin
      HRDATA = mem_rdata;
      for (int i = 0; i < 4; i++) begin
         if (byp_strb_q[i]) HRDATA[8*i +: 8] = byp_data_q[8*i +: 8];
      end
   end

endmodule

// File: tb/tb_ahb_sram_resp.sv
// Bench for ahb_sram_resp: three instances (0, 3 and 2 wait states) driven by a
// pipelined AHB master task and checked against a byte-array memory model.
module tb_ahb_sram_resp;

   localparam int AW = 14;

   logic hclk = 1'b0;
   always #5 hclk = ~hclk;

   logic        hresetn   [3];
   logic        hsel      [3];
   logic [31:0] haddr     [3];
   logic [1:0]  htrans    [3];
   logic [2:0]  hsize     [3];
   logic        hwrite    [3];
   logic [31:0] hwdata    [3];
   logic        hreadyout [3];
   logic        hresp     [3];
   logic [31:0] hrdata    [3];

   ahb_sram_resp #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) u_dut0 (
      .HCLK(hclk), .HRESETn(hresetn[0]), .HSEL(hsel[0]), .HADDR(haddr[0]),
      .HTRANS(htrans[0]), .HSIZE(hsize[0]), .HWRITE(hwrite[0]), .HWDATA(hwdata[0]),
      .HREADY(hreadyout[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0]));

   ahb_sram_resp #(.ADDR_WIDTH(AW), .WAIT_STATES(3)) u_dut1 (
      .HCLK(hclk), .HRESETn(hresetn[1]), .HSEL(hsel[1]), .HADDR(haddr[1]),
      .HTRANS(htrans[1]), .HSIZE(hsize[1]), .HWRITE(hwrite[1]), .HWDATA(hwdata[1]),
      .HREADY(hreadyout[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1]));

   ahb_sram_resp #(.ADDR_WIDTH(AW), .WAIT_STATES(2)) u_dut2 (
      .HCLK(hclk), .HRESETn(hresetn[2]), .HSEL(hsel[2]), .HADDR(haddr[2]),
      .HTRANS(htrans[2]), .HSIZE(hsize[2]), .HWRITE(hwrite[2]), .HWDATA(hwdata[2]),
      .HREADY(hreadyout[2]), .HREADYOUT(hreadyout[2]), .HRESP(hresp[2]), .HRDATA(hrdata[2]));

   typedef struct {
      bit          wr;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } txn_t;

   txn_t        tq[$];
   logic [7:0]  model [3][1 << AW];
   logic [31:0] last_rd;
   int          n_checks = 0;
   int          n_pass   = 0;

   function automatic int ws_of(int d);
      return (d == 0) ? 0 : (d == 1) ? 3 : 2;
   endfunction

   function automatic bit is_legal(logic [2:0] size, logic [31:0] addr);
      return (size == 3'd0) || (size == 3'd1 && addr[0] == 1'b0) ||
             (size == 3'd2 && addr[1:0] == 2'b00);
   endfunction

   function automatic int word_base(logic [31:0] addr);
      return int'(addr % (1 << AW)) / 4 * 4;
   endfunction

   function automatic logic [31:0] model_word(int d, logic [31:0] addr);
      int b;
      b = word_base(addr);
      return {model[d][b+3], model[d][b+2], model[d][b+1], model[d][b]};
   endfunction

   task automatic model_write(int d, txn_t t);
      int nbytes, lane;
      nbytes = 1 << t.size;
      for (int i = 0; i < nbytes; i++) begin
         lane = int'(t.addr[1:0]) + i;
         model[d][word_base(t.addr) + lane] = t.wdata[8*lane +: 8];
      end
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
   endtask

   task automatic push(bit wr, logic [2:0] size, logic [31:0] addr, logic [31:0] wdata);
      txn_t t;
      t.wr = wr; t.size = size; t.addr = addr; t.wdata = wdata;
      tq.push_back(t);
   endtask

   // Issues every queued transfer back-to-back and checks each data phase.
   task automatic run_pipe(int d, string tag);
      int   a, dph, waits, cyc;
      bit   done, rdy, rsp, lg;
      logic [31:0] rd;
      a = 0; dph = -1; waits = 0; cyc = 0; done = 0; lg = 0;
      @(posedge hclk); #1;
      while (!done) begin
         if (a < tq.size()) begin
            hsel[d]   = 1'b1;
            htrans[d] = 2'b10;
            haddr[d]  = tq[a].addr;
            hsize[d]  = tq[a].size;
            hwrite[d] = tq[a].wr;
         end else begin
            hsel[d]   = 1'b0;
            htrans[d] = 2'b00;
         end
         @(negedge hclk);
         rdy = hreadyout[d]; rsp = hresp[d]; rd = hrdata[d];
         if (dph >= 0) begin
            lg = is_legal(tq[dph].size, tq[dph].addr);
            if (!rdy) begin
               waits++;
               chk({tag, " wait-cycle resp"}, 32'(rsp), lg ? 32'd0 : 32'd1);
               hwdata[d] = $urandom;
            end else if (tq[dph].wr) begin
               hwdata[d] = tq[dph].wdata;
            end
         end else begin
            chk({tag, " idle ready"}, 32'(rdy), 32'd1);
            chk({tag, " idle resp"}, 32'(rsp), 32'd0);
         end
         @(posedge hclk); #1;
         cyc++;
         if (rdy) begin
            if (dph >= 0) begin
               chk({tag, " wait count"}, 32'(waits), lg ? 32'(ws_of(d)) : 32'd1);
               chk({tag, " final resp"}, 32'(rsp), lg ? 32'd0 : 32'd1);
               if (lg && !tq[dph].wr) begin
                  chk({tag, " read data"}, rd, model_word(d, tq[dph].addr));
                  last_rd = rd;
               end
               if (lg && tq[dph].wr) model_write(d, tq[dph]);
               waits = 0;
            end
            if (a < tq.size()) begin
               dph = a;
               a++;
            end else begin
               dph = -1;
            end
         end
         if (dph < 0 && a >= tq.size()) done = 1;
         if (cyc > 600) begin
            chk({tag, " cycle budget"}, 32'(cyc), 32'd600);
            done = 1;
         end
      end
      tq.delete();
   endtask

   task automatic fill_region(int d, string tag);
      for (int w = 0; w < 64; w++) push(1'b1, 3'd2, 32'h100 + 32'(w * 4), $urandom);
      run_pipe(d, tag);
   endtask

   task automatic random_mix(int d, int n, string tag);
      logic [2:0]  size;
      logic [31:0] addr;
      for (int i = 0; i < n; i++) begin
         size = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
         addr = 32'h100 + 32'($urandom_range(0, 255));
         if (size < 3'd3 && $urandom_range(0, 4) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
         addr = addr | (32'($urandom_range(0, 15)) << AW);
         push(1'($urandom_range(0, 1)), size, addr, $urandom);
      end
      run_pipe(d, tag);
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         hresetn[d] = 1'b0; hsel[d] = 1'b0; htrans[d] = 2'b00; haddr[d] = '0;
         hsize[d] = 3'd0; hwrite[d] = 1'b0; hwdata[d] = '0;
      end
      last_rd = '0;
      repeat (3) @(posedge hclk);
      #1;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("reset ready d%0d", d), 32'(hreadyout[d]), 32'd1);
         chk($sformatf("reset resp d%0d", d), 32'(hresp[d]), 32'd0);
         chk($sformatf("reset rdata d%0d", d), hrdata[d], 32'd0);
      end
      @(negedge hclk);
      for (int d = 0; d < 3; d++) hresetn[d] = 1'b1;

      push(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
      push(1'b0, 3'd2, 32'h10, 32'h0);
      run_pipe(0, "word wr/rd");
      chk("word wr/rd value", last_rd, 32'hDEADBEEF);

      push(1'b1, 3'd2, 32'h20, 32'h0);
      push(1'b1, 3'd0, 32'h21, 32'h0000_AA00);
      push(1'b1, 3'd1, 32'h22, 32'h1234_0000);
      push(1'b0, 3'd2, 32'h20, 32'h0);
      run_pipe(0, "lanes");
      chk("lanes value", last_rd, 32'h1234_AA00);

      push(1'b1, 3'd2, 32'h40, 32'h1122_3344);
      push(1'b0, 3'd2, 32'h40, 32'h0);
      run_pipe(0, "raw word");
      chk("raw word value", last_rd, 32'h1122_3344);
      push(1'b1, 3'd0, 32'h43, 32'hFF00_0000);
      push(1'b0, 3'd2, 32'h40, 32'h0);
      run_pipe(0, "raw byte");
      chk("raw byte value", last_rd, 32'hFF22_3344);

      push(1'b1, 3'd2, 32'h0, 32'h5A5A_5A5A);
      run_pipe(0, "err setup");
      push(1'b0, 3'd2, 32'h2, 32'h0);
      push(1'b0, 3'd3, 32'h0, 32'h0);
      push(1'b1, 3'd2, 32'h2, 32'hFFFF_FFFF);
      push(1'b1, 3'd1, 32'h1, 32'hFFFF_FFFF);
      push(1'b1, 3'd3, 32'h0, 32'hFFFF_FFFF);
      push(1'b0, 3'd2, 32'h0, 32'h0);
      run_pipe(0, "error");
      chk("error mem unchanged", last_rd, 32'h5A5A_5A5A);

      push(1'b1, 3'd2, 32'hABC0_4050, 32'h7777_1234);
      push(1'b0, 3'd2, 32'h0000_0050, 32'h0);
      run_pipe(0, "wrap");
      chk("wrap value", last_rd, 32'h7777_1234);

      fill_region(0, "fill d0");
      random_mix(0, 80, "rand d0");

      fill_region(1, "fill d1");
      push(1'b0, 3'd2, 32'h104, 32'h0);
      run_pipe(1, "ws3 single");
      push(1'b0, 3'd2, 32'h108, 32'h0);
      push(1'b0, 3'd2, 32'h10C, 32'h0);
      push(1'b0, 3'd2, 32'h110, 32'h0);
      run_pipe(1, "ws3 b2b");
      push(1'b1, 3'd2, 32'h120, 32'hA5A5_0F0F);
      push(1'b0, 3'd2, 32'h120, 32'h0);
      push(1'b0, 3'd2, 32'h3, 32'h0);
      run_pipe(1, "ws3 raw/err");
      random_mix(1, 60, "rand d1");

      push(1'b1, 3'd2, 32'h80, 32'hCAFE_F00D);
      push(1'b0, 3'd2, 32'h80, 32'h0);
      run_pipe(2, "rst pre");
      chk("rst pre value", last_rd, 32'hCAFE_F00D);
      hsel[2] = 1'b1; htrans[2] = 2'b10; haddr[2] = 32'h80; hsize[2] = 3'd2; hwrite[2] = 1'b1;
      @(posedge hclk); #1;
      hsel[2] = 1'b0; htrans[2] = 2'b00; hwdata[2] = 32'h1234_5678;
      @(negedge hclk);
      chk("rst in-wait ready", 32'(hreadyout[2]), 32'd0);
      #2 hresetn[2] = 1'b0;
      #1;
      chk("rst ready", 32'(hreadyout[2]), 32'd1);
      chk("rst resp", 32'(hresp[2]), 32'd0);
      chk("rst rdata", hrdata[2], 32'd0);
      @(posedge hclk);
      @(negedge hclk);
      hresetn[2] = 1'b1;
      push(1'b0, 3'd2, 32'h80, 32'h0);
      run_pipe(2, "rst post");
      chk("rst dropped write", last_rd, 32'hCAFE_F00D);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
